// File: rtl/byte_serial_add_sequencer.sv
// Byte-serial operand/result sequencer around an 8-bit adder core.
// Ports: clk, rst_n, in_* byte input, add_* adder link, out_* result; SEQ_SUB_EN adds op_sub.
module byte_serial_add_sequencer #(
  parameter int MAX_BYTES = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
`ifdef SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_trunc
);

  typedef enum logic {
    ST_START,
    ST_BODY
  } state_t;

  state_t state_q, state_d;

  logic             op_valid_q;
  logic             op_last_q;
  logic [7:0]       op_a_q;
  logic [7:0]       op_b_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;

  logic             out_valid_q;
  logic [7:0]       out_sum_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_last_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_trunc_q;

  logic first;
  logic adv;
  logic accept;
  logic eff_last;
  logic ovf;
  logic sub;

  assign first  = (state_q == ST_START);
  assign adv    = op_valid_q && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;

  assign in_ready = !op_valid_q || adv;

  // Word ends on the flagged byte or when the index hits the limit.
  assign eff_last = op_last_q ||
                    (idx_q == IDX_W'(MAX_BYTES - 1));

`ifdef SEQ_SUB_EN
  logic op_sub_q;
  logic word_sub_q;

  // Mode comes from the word's first byte; later bytes reuse it.
  assign sub = first ? op_sub_q : word_sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sub_q   <= 1'b0;
      word_sub_q <= 1'b0;
    end else begin
      if (accept) op_sub_q <= op_sub;
      if (adv && first) word_sub_q <= op_sub_q;
    end
  end
`else
  assign sub = 1'b0;
`endif

  assign add_a   = op_a_q;
  assign add_b   = sub ? ~op_b_q : op_b_q;
  assign add_cin = first ? sub : carry_q;

  assign ovf = (add_a[7] == add_b[7]) &&
               (add_sum[7] != add_a[7]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    if (adv) begin
      carry_d = add_cout;
      if (eff_last) begin
        state_d = ST_START;
        idx_d   = '0;
      end else begin
        state_d = ST_BODY;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_last_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else if (accept) begin
      op_valid_q <= 1'b1;
      op_last_q  <= in_last;
      op_a_q     <= in_a;
      op_b_q     <= in_b;
    end else if (adv) begin
      op_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= add_sum;
      out_idx_q   <= idx_q;
      out_last_q  <= eff_last;
      out_cout_q  <= eff_last && add_cout;
      out_ovf_q   <= eff_last && ovf;
      out_trunc_q <= eff_last && !op_last_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_trunc = out_trunc_q;

endmodule
